ex_stage_alu_unit: RTL and testbench

- Execute (EX) stage, directly downstream of the ID/EX control pipeline registers.
- Consumes the registered one-hot control signals (add, sub, and, or, slt, mul) and the two operands.
- Computes the result and registers it into the EX/MEM boundary.
- Single-cycle ops complete in 1 clock. Multiply is iterative shift-add (32 iterations) and stalls the upstream stages through a handshake.

---
 rtl/ex_stage_alu_unit.sv | 174 +++++++++++++++++
 tb/tb_ex_stage_alu_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_alu_unit.sv
// EX stage: single-cycle add/sub/and/or/slt and a 32-iteration shift-add multiply
// that stalls the upstream pipeline; results are registered into the EX/MEM boundary.
//
// state | meaning
// IDLE  | accepting instructions; single-cycle ops retire on the next edge
// BUSY  | multiply iterating; inputs ignored, upstream stalled until the last iteration
module ex_stage_alu_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic                      add_control,
    input  logic                      sub_control,
    input  logic                      and_control,
    input  logic                      or_control,
    input  logic                      slt_control,
    input  logic                      mul_control,
    input  logic [DATA_WIDTH-1:0]     operand_a,
    input  logic [DATA_WIDTH-1:0]     operand_b,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg_in,
    input  logic                      reg_write_in,
    output logic                      stall_out,
    output logic [DATA_WIDTH-1:0]     ex_mem_result,
    output logic [REG_ADDR_WIDTH-1:0] ex_mem_dest_reg,
    output logic                      ex_mem_reg_write,
    output logic                      ex_mem_overflow,
    output logic                      ex_mem_valid
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);
    localparam int MSB = DATA_WIDTH - 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]          iter_cnt;
    logic [DATA_WIDTH-1:0]     mcand;
    logic [DATA_WIDTH-1:0]     mplier;
    logic [DATA_WIDTH-1:0]     acc;
    logic [DATA_WIDTH-1:0]     acc_next;
    logic [REG_ADDR_WIDTH-1:0] cap_dest;
    logic                      cap_wr;

    logic                  mul_start;
    logic                  mul_last;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  a_lt_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_ovf;

    assign mul_start = valid_in & mul_control;
    assign mul_last  = (state == BUSY) && (iter_cnt == LAST_ITER);
    assign acc_next  = mplier[0] ? (acc + mcand) : acc;

    assign sum    = operand_a + operand_b;
    assign diff   = operand_a - operand_b;
    assign a_lt_b = $signed(operand_a) < $signed(operand_b);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The last BUSY cycle drops stall so the upstream advances with the product write.
    always_comb begin
        state_nxt = state;
        stall_out = 1'b0;
        case (state)
            IDLE: begin
                if (mul_start) begin
                    state_nxt = BUSY;
                    stall_out = 1'b1;
                end
            end
            BUSY: begin
                if (mul_last) begin
                    state_nxt = IDLE;
                end else begin
                    stall_out = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            stall_out = 1'b0;
        end
    end

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        if (add_control) begin
            alu_result = sum;
            alu_ovf    = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
        end else if (sub_control) begin
            alu_result = diff;
            alu_ovf    = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
        end else if (and_control) begin
            alu_result = operand_a & operand_b;
        end else if (or_control) begin
            alu_result = operand_a | operand_b;
        end else if (slt_control) begin
            alu_result = {{(DATA_WIDTH-1){1'b0}}, a_lt_b};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iter_cnt <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cap_dest <= '0;
            cap_wr   <= 1'b0;
        end else if (state == IDLE) begin
            if (mul_start) begin
                iter_cnt <= '0;
                mcand    <= operand_a;
                mplier   <= operand_b;
                acc      <= '0;
                cap_dest <= dest_reg_in;
                cap_wr   <= reg_write_in;
            end
        end else begin
            acc      <= acc_next;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            iter_cnt <= iter_cnt + CNT_W'(1);
        end
    end

    // Only the low product word is kept, so unsigned shift-add also serves signed operands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_mem_result    <= '0;
            ex_mem_dest_reg  <= '0;
            ex_mem_reg_write <= 1'b0;
            ex_mem_overflow  <= 1'b0;
            ex_mem_valid     <= 1'b0;
        end else if (state == BUSY) begin
            if (mul_last) begin
                ex_mem_result    <= acc_next;
                ex_mem_dest_reg  <= cap_dest;
                ex_mem_reg_write <= cap_wr;
                ex_mem_overflow  <= 1'b0;
                ex_mem_valid     <= 1'b1;
            end else begin
                ex_mem_reg_write <= 1'b0;
                ex_mem_valid     <= 1'b0;
            end
        end else if (valid_in && !mul_control) begin
            ex_mem_result    <= alu_result;
            ex_mem_dest_reg  <= dest_reg_in;
            ex_mem_reg_write <= reg_write_in;
            ex_mem_overflow  <= alu_ovf;
            ex_mem_valid     <= 1'b1;
        end else begin
            ex_mem_reg_write <= 1'b0;
            ex_mem_valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_alu_unit.sv
// Bench for ex_stage_alu_unit: directed vector table, multiply/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_ex_stage_alu_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        add_control, sub_control, and_control, or_control, slt_control, mul_control;
    logic [31:0] operand_a, operand_b;
    logic [4:0]  dest_reg_in;
    logic        reg_write_in;
    logic        stall_out;
    logic [31:0] ex_mem_result;
    logic [4:0]  ex_mem_dest_reg;
    logic        ex_mem_reg_write, ex_mem_overflow, ex_mem_valid;

    int checks   = 0;
    int failures = 0;

    // expected EX/MEM contents
    logic [31:0] m_res;
    logic [4:0]  m_dest;
    logic        m_wr, m_ovf, m_valid;

    // ctl bit order: {mul, add, sub, and, or, slt}
    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        wr;
        logic [31:0] exp_res;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[12];

    ex_stage_alu_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in),
        .add_control(add_control), .sub_control(sub_control), .and_control(and_control),
        .or_control(or_control), .slt_control(slt_control), .mul_control(mul_control),
        .operand_a(operand_a), .operand_b(operand_b), .dest_reg_in(dest_reg_in),
        .reg_write_in(reg_write_in), .stall_out(stall_out), .ex_mem_result(ex_mem_result),
        .ex_mem_dest_reg(ex_mem_dest_reg), .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_overflow(ex_mem_overflow), .ex_mem_valid(ex_mem_valid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " result"}, 64'(ex_mem_result), 64'(m_res));
        chk({tag, " dest"}, 64'(ex_mem_dest_reg), 64'(m_dest));
        chk({tag, " reg_write"}, 64'(ex_mem_reg_write), 64'(m_wr));
        chk({tag, " overflow"}, 64'(ex_mem_overflow), 64'(m_ovf));
        chk({tag, " valid"}, 64'(ex_mem_valid), 64'(m_valid));
    endtask

    task automatic model_reset();
        m_res = '0; m_dest = '0; m_wr = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    endtask

    // Reference ALU from signed/unsigned arithmetic; priority add > sub > and > or > slt.
    task automatic ref_alu(input logic [5:0] ctl, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic o);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0;
        o = 1'b0;
        if (ctl[4]) begin
            s = sa + sb;
            r = s[31:0];
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (ctl[3]) begin
            s = sa - sb;
            r = s[31:0];
            o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (ctl[2]) begin
            r = a & b;
        end else if (ctl[1]) begin
            r = a | b;
        end else if (ctl[0]) begin
            r = (sa < sb) ? 32'd1 : 32'd0;
        end
    endtask

    task automatic drive(input logic [5:0] ctl, input logic vld, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic w);
        mul_control = ctl[5]; add_control = ctl[4]; sub_control = ctl[3];
        and_control = ctl[2]; or_control = ctl[1]; slt_control = ctl[0];
        valid_in = vld; operand_a = a; operand_b = b; dest_reg_in = d; reg_write_in = w;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_single(input string tag, input logic [5:0] ctl, input logic vld,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] d, input logic w);
        logic [31:0] r;
        logic o;
        drive({1'b0, ctl[4:0]}, vld, a, b, d, w);
        tick();
        if (vld) begin
            ref_alu(ctl, a, b, r, o);
            m_res = r; m_ovf = o; m_dest = d; m_wr = w; m_valid = 1'b1;
        end else begin
            m_valid = 1'b0; m_wr = 1'b0;
        end
        check_all(tag);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Multiply issued now (edge E is the next edge); expects the product at E+32.
    task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic w);
        logic [63:0] p;
        int stall_cnt;
        int lat;
        bit got;
        stall_cnt = 0;
        lat = -1;
        got = 1'b0;
        drive(6'b100000, 1'b1, a, b, d, w);
        #1;
        for (int e = 0; e < 40; e++) begin
            if (stall_out) stall_cnt++;
            tick();
            if (ex_mem_valid) begin
                got = 1'b1;
                lat = e;
                break;
            end
            chk({tag, " busy reg_write"}, 64'(ex_mem_reg_write), 64'd0);
            drive(6'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom));
            #1;
        end
        chk({tag, " product seen"}, 64'(got), 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'd32);
        chk({tag, " stall cycles"}, 64'(stall_cnt), 64'd32);
        p = 64'(a) * 64'(b);
        m_res = p[31:0]; m_dest = d; m_wr = w; m_ovf = 1'b0; m_valid = 1'b1;
        check_all(tag);
    endtask

    initial begin
        vecs[0]  = '{6'b010000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3,  1'b1, 32'h8000_0000, 1'b1};
        vecs[1]  = '{6'b001000, 32'd5,         32'd7,         5'd4,  1'b0, 32'hFFFF_FFFE, 1'b0};
        vecs[2]  = '{6'b000001, 32'hFFFF_FFFF, 32'd1,         5'd5,  1'b1, 32'd1,         1'b0};
        vecs[3]  = '{6'b000100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6,  1'b1, 32'h00F0_00F0, 1'b0};
        vecs[4]  = '{6'b000010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd7,  1'b1, 32'hFFF0_FFF0, 1'b0};
        vecs[5]  = '{6'b000000, 32'h1234_5678, 32'h9ABC_DEF0, 5'd8,  1'b1, 32'd0,         1'b0};
        vecs[6]  = '{6'b001000, 32'h8000_0000, 32'd1,         5'd9,  1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[7]  = '{6'b011000, 32'd1,         32'd1,         5'd10, 1'b1, 32'd2,         1'b0};
        vecs[8]  = '{6'b000001, 32'd1,         32'hFFFF_FFFF, 5'd11, 1'b1, 32'd0,         1'b0};
        vecs[9]  = '{6'b010000, 32'hFFFF_FFFF, 32'd1,         5'd12, 1'b1, 32'd0,         1'b0};
        vecs[10] = '{6'b000111, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd13, 1'b1, 32'h0F00_0F00, 1'b0};
        vecs[11] = '{6'b010000, 32'd2,         32'd3,         5'd14, 1'b1, 32'd5,         1'b0};

        reset = 1'b1;
        drive(6'b0, 1'b0, '0, '0, '0, 1'b0);
        model_reset();
        repeat (2) tick();
        check_all("reset");
        chk("reset stall", 64'(stall_out), 64'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive({1'b0, vecs[i].ctl[4:0]}, 1'b1, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].wr);
            tick();
            chk($sformatf("vec%0d result", i), 64'(ex_mem_result), 64'(vecs[i].exp_res));
            chk($sformatf("vec%0d overflow", i), 64'(ex_mem_overflow), 64'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d valid", i), 64'(ex_mem_valid), 64'd1);
            chk($sformatf("vec%0d dest", i), 64'(ex_mem_dest_reg), 64'(vecs[i].dest));
            chk($sformatf("vec%0d reg_write", i), 64'(ex_mem_reg_write), 64'(vecs[i].wr));
            m_res = vecs[i].exp_res; m_ovf = vecs[i].exp_ovf; m_dest = vecs[i].dest;
            m_wr = vecs[i].wr; m_valid = 1'b1;
        end

        apply_single("bubble", 6'b010000, 1'b0, 32'd9, 32'd9, 5'd1, 1'b1);

        // asynchronous reset mid-cycle with live outputs and a pending multiply
        apply_single("pre-reset add", 6'b010000, 1'b1, 32'h7FFF_FFFF, 32'd2, 5'd21, 1'b1);
        drive(6'b100000, 1'b1, 32'd3, 32'd4, 5'd2, 1'b1);
        #1;
        chk("stall before E", 64'(stall_out), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async reset");
        chk("async reset stall", 64'(stall_out), 64'd0);
        drive(6'b0, 1'b0, '0, '0, '0, 1'b0);
        #2;
        reset = 1'b0;
        tick();

        do_mul("mul 12345x6789", 32'd12345, 32'd6789, 5'd17, 1'b1);
        do_mul("mul ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd18, 1'b1);
        apply_single("add after mul", 6'b010000, 1'b1, 32'd2, 32'd3, 5'd19, 1'b1);
        do_mul("mul zero", 32'd0, 32'd5, 5'd20, 1'b0);

        // abort a multiply at iteration 10
        drive(6'b100000, 1'b1, 32'd1000, 32'd1000, 5'd22, 1'b1);
        tick();
        drive(6'b0, 1'b0, '0, '0, '0, 1'b0);
        repeat (10) tick();
        chk("mid-mul stall", 64'(stall_out), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("abort reset");
        chk("abort stall", 64'(stall_out), 64'd0);
        #2;
        reset = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                tick();
                if (ex_mem_valid || stall_out) seen++;
            end
            chk("no product after abort", 64'(seen), 64'd0);
        end
        apply_single("add after abort", 6'b010000, 1'b1, 32'd1, 32'd1, 5'd23, 1'b1);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] ctl;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0: ctl = 6'b010000;
                1: ctl = 6'b001000;
                2: ctl = 6'b000100;
                3: ctl = 6'b000010;
                4: ctl = 6'b000001;
                5: ctl = 6'b000000;
                default: ctl = {1'b0, 5'($urandom)};
            endcase
            apply_single($sformatf("rand%0d", n), ctl, ($urandom_range(0, 6) != 0),
                         rand_operand(), rand_operand(), 5'($urandom), 1'($urandom));
            if (n % 75 == 74) begin
                do_mul($sformatf("rand mul%0d", n), rand_operand(), $urandom,
                       5'($urandom), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
